// File: rtl/riscv_pkg.sv
// Shared encodings for the pipeline memory path.
// Arbiter state codes and the ResultSrc value that marks a load.
package riscv_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'b00,
        ARB_DATA  = 2'b01,
        ARB_FETCH = 2'b10
    } arb_state_e;

    localparam logic [1:0] RES_MEM = 2'b01;

endpackage

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between fetch (F) and memory (M) stages.
// Data wins conflicts; a fetch that lost wins the next arbitration.
module mem_port_arbiter
    import riscv_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          IReqF,
    input  logic [AW-1:0] PCF,
    input  logic          DReqM,
    input  logic          DWeM,
    input  logic [AW-1:0] ALUResultM,
    input  logic [DW-1:0] WriteDataM,
    input  logic          RedirectE,
    output logic          MemReq,
    output logic          MemWe,
    output logic [AW-1:0] MemAddr,
    output logic [DW-1:0] MemWData,
    input  logic [DW-1:0] MemRData,
    input  logic          MemReady,
    output logic [DW-1:0] InstrF,
    output logic [DW-1:0] ReadDataM,
    output logic          ArbStallF,
    output logic          ArbStallM
);

    arb_state_e    state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          we_q, we_d;
    logic          last_q, last_d;
    logic          disc_q, disc_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [DW-1:0] instr_q, instr_d;

    logic          data_done;
    logic          fetch_ok;

    assign data_done = (state_q == ARB_DATA) & MemReady;
    assign fetch_ok  = (state_q == ARB_FETCH) & MemReady & ~disc_q & ~RedirectE;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        last_d  = last_q;
        disc_d  = disc_q;
        rdata_d = rdata_q;
        instr_d = instr_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (DReqM && !(last_q && IReqF)) begin
                    addr_d  = ALUResultM;
                    wdata_d = WriteDataM;
                    we_d    = DWeM;
                    state_d = ARB_DATA;
                end else if (IReqF) begin
                    addr_d  = PCF;
                    we_d    = 1'b0;
                    state_d = ARB_FETCH;
                end
            end
            ARB_DATA: begin
                if (MemReady) begin
                    state_d = ARB_IDLE;
                    last_d  = 1'b1;
                    if (!we_q) begin
                        rdata_d = MemRData;
                    end
                end
            end
            ARB_FETCH: begin
                if (MemReady) begin
                    state_d = ARB_IDLE;
                    last_d  = 1'b0;
                    disc_d  = 1'b0;
                    if (fetch_ok) begin
                        instr_d = MemRData;
                    end
                end else if (RedirectE) begin
                    // wrong-path fetch still completes, but its data is dropped
                    disc_d = 1'b1;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ARB_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            last_q  <= 1'b0;
            disc_q  <= 1'b0;
            rdata_q <= '0;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            last_q  <= last_d;
            disc_q  <= disc_d;
            rdata_q <= rdata_d;
            instr_q <= instr_d;
        end
    end

    assign MemReq    = (state_q != ARB_IDLE);
    assign MemWe     = (state_q == ARB_DATA) & we_q;
    assign MemAddr   = addr_q;
    assign MemWData  = wdata_q;
    assign ReadDataM = (data_done & ~we_q) ? MemRData : rdata_q;
    assign InstrF    = fetch_ok ? MemRData : instr_q;
    assign ArbStallM = DReqM & ~data_done;
    assign ArbStallF = IReqF & ~fetch_ok;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter.
// Inputs change 1ns after the rising edge; outputs checked before the next edge.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        IReqF;
    logic [31:0] PCF;
    logic        DReqM;
    logic        DWeM;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic        RedirectE;
    logic        MemReq;
    logic        MemWe;
    logic [31:0] MemAddr;
    logic [31:0] MemWData;
    logic [31:0] MemRData;
    logic        MemReady;
    logic [31:0] InstrF;
    logic [31:0] ReadDataM;
    logic        ArbStallF;
    logic        ArbStallM;

    int total;
    int bad;

    mem_port_arbiter #(.AW(32), .DW(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .IReqF      (IReqF),
        .PCF        (PCF),
        .DReqM      (DReqM),
        .DWeM       (DWeM),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .RedirectE  (RedirectE),
        .MemReq     (MemReq),
        .MemWe      (MemWe),
        .MemAddr    (MemAddr),
        .MemWData   (MemWData),
        .MemRData   (MemRData),
        .MemReady   (MemReady),
        .InstrF     (InstrF),
        .ReadDataM  (ReadDataM),
        .ArbStallF  (ArbStallF),
        .ArbStallM  (ArbStallM)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        rst        = 1'b0;
        IReqF      = 1'b0;
        PCF        = '0;
        DReqM      = 1'b0;
        DWeM       = 1'b0;
        ALUResultM = '0;
        WriteDataM = '0;
        RedirectE  = 1'b0;
        MemRData   = '0;
        MemReady   = 1'b0;
        tick();
        tick();
        chk("rst_memreq", {31'b0, MemReq}, 32'd0);
        chk("rst_memwe", {31'b0, MemWe}, 32'd0);
        chk("rst_instr", InstrF, 32'h0);
        chk("rst_rdata", ReadDataM, 32'h0);
        chk("rst_stallf", {31'b0, ArbStallF}, 32'd0);
        rst = 1'b1;

        // fetch only, latency 1
        IReqF = 1'b1;
        PCF   = 32'h10;
        #1;
        chk("f1_stall_idle", {31'b0, ArbStallF}, 32'd1);
        chk("f1_req_idle", {31'b0, MemReq}, 32'd0);
        tick();
        chk("f1_req", {31'b0, MemReq}, 32'd1);
        chk("f1_addr", MemAddr, 32'h10);
        chk("f1_we", {31'b0, MemWe}, 32'd0);
        MemReady = 1'b1;
        MemRData = 32'h00500093;
        #1;
        chk("f1_stall_done", {31'b0, ArbStallF}, 32'd0);
        chk("f1_instr", InstrF, 32'h00500093);
        tick();
        MemReady = 1'b0;
        IReqF    = 1'b0;
        MemRData = 32'hFFFF0000;
        #1;
        chk("f1_instr_hold", InstrF, 32'h00500093);
        chk("f1_req_off", {31'b0, MemReq}, 32'd0);

        // conflict: data first, then fetch wins once
        IReqF      = 1'b1;
        PCF        = 32'h14;
        DReqM      = 1'b1;
        DWeM       = 1'b0;
        ALUResultM = 32'h200;
        tick();
        chk("c_addr_data", MemAddr, 32'h200);
        chk("c_we_data", {31'b0, MemWe}, 32'd0);
        chk("c_stallm", {31'b0, ArbStallM}, 32'd1);
        chk("c_stallf", {31'b0, ArbStallF}, 32'd1);
        tick();
        chk("c_addr_wait", MemAddr, 32'h200);
        tick();
        MemReady = 1'b1;
        MemRData = 32'h11112222;
        #1;
        chk("c_rdata", ReadDataM, 32'h11112222);
        chk("c_stallm_done", {31'b0, ArbStallM}, 32'd0);
        tick();
        MemReady   = 1'b0;
        ALUResultM = 32'h204;
        #1;
        chk("c_stallm_again", {31'b0, ArbStallM}, 32'd1);
        tick();
        chk("c_fetch_wins", MemAddr, 32'h14);
        chk("c_rdata_hold", ReadDataM, 32'h11112222);
        MemReady = 1'b1;
        MemRData = 32'h00000013;
        #1;
        chk("c_instr", InstrF, 32'h00000013);
        tick();
        MemReady = 1'b0;
        #1;
        chk("c_instr_hold", InstrF, 32'h00000013);
        tick();
        chk("c_data_next", MemAddr, 32'h204);
        MemReady = 1'b1;
        MemRData = 32'h33334444;
        #1;
        chk("c_rdata2", ReadDataM, 32'h33334444);
        tick();
        MemReady = 1'b0;
        IReqF    = 1'b0;
        DReqM    = 1'b0;

        // store with 10 wait states
        DReqM      = 1'b1;
        DWeM       = 1'b1;
        ALUResultM = 32'h40;
        WriteDataM = 32'hDEADBEEF;
        tick();
        ALUResultM = 32'h9999;
        WriteDataM = 32'h12345678;
        DWeM       = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("s_we", {31'b0, MemWe}, 32'd1);
            chk("s_addr", MemAddr, 32'h40);
            chk("s_wdata", MemWData, 32'hDEADBEEF);
            chk("s_stallm", {31'b0, ArbStallM}, 32'd1);
            tick();
        end
        MemReady = 1'b1;
        MemRData = 32'hBADBAD00;
        #1;
        chk("s_stallm_done", {31'b0, ArbStallM}, 32'd0);
        chk("s_rdata_same", ReadDataM, 32'h33334444);
        tick();
        MemReady = 1'b0;
        DReqM    = 1'b0;
        #1;
        chk("s_rdata_after", ReadDataM, 32'h33334444);
        chk("s_we_off", {31'b0, MemWe}, 32'd0);

        // redirect during fetch
        IReqF = 1'b1;
        PCF   = 32'h80;
        tick();
        chk("r_addr_old", MemAddr, 32'h80);
        RedirectE = 1'b1;
        #1;
        chk("r_stall_redir", {31'b0, ArbStallF}, 32'd1);
        tick();
        RedirectE = 1'b0;
        PCF       = 32'h100;
        MemReady  = 1'b1;
        MemRData  = 32'h0000AAAA;
        #1;
        chk("r_instr_kept", InstrF, 32'h00000013);
        chk("r_stall_disc", {31'b0, ArbStallF}, 32'd1);
        tick();
        MemReady = 1'b0;
        #1;
        chk("r_instr_noupd", InstrF, 32'h00000013);
        chk("r_stall_idle", {31'b0, ArbStallF}, 32'd1);
        tick();
        chk("r_addr_new", MemAddr, 32'h100);
        MemReady = 1'b1;
        MemRData = 32'h00100073;
        #1;
        chk("r_instr_new", InstrF, 32'h00100073);
        chk("r_stall_clr", {31'b0, ArbStallF}, 32'd0);
        tick();
        MemReady = 1'b0;
        IReqF    = 1'b0;

        // async reset mid-DATA
        DReqM      = 1'b1;
        DWeM       = 1'b0;
        ALUResultM = 32'h300;
        tick();
        chk("a_req_data", {31'b0, MemReq}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("a_req_drop", {31'b0, MemReq}, 32'd0);
        chk("a_stallm", {31'b0, ArbStallM}, 32'd1);
        chk("a_rdata_clr", ReadDataM, 32'h0);
        chk("a_instr_clr", InstrF, 32'h0);
        chk("a_addr_clr", MemAddr, 32'h0);
        tick();
        rst = 1'b1;
        #1;
        chk("a_idle", {31'b0, MemReq}, 32'd0);
        tick();
        chk("a_resume_addr", MemAddr, 32'h300);
        MemReady = 1'b1;
        MemRData = 32'h00005555;
        #1;
        chk("a_resume_rdata", ReadDataM, 32'h00005555);
        tick();
        MemReady = 1'b0;
        DReqM    = 1'b0;
        #1;
        chk("a_end_idle", {31'b0, MemReq}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
